svc_str_collect: RTL and testbench
==================================

Name: svc_str_collect

Overview:
- Receive side of the character stream. Accepts one ASCII char per valid/ready beat and accumulates chars into a packed message.
- On a terminator char, or when the buffer fills, it emits the whole message with its length on a valid/ready master port.
- Message packing matches a SystemVerilog string literal assigned to a MAX_STR_LEN*8 vector: right-justified, first char in the most significant used byte, unused upper bytes zero. The output can therefore be fed straight back into svc_str_iter.

Parameters:
- MAX_STR_LEN, 16, maximum chars per message. Must be >= 1.
- TERM_CHAR, 8'h0A, terminator char. It is consumed but never stored.
- MSG_WIDTH (localparam), MAX_STR_LEN*8.
- LEN_WIDTH (localparam), $clog2(MAX_STR_LEN+1).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- s_valid  input  1  char valid
- s_char  input  8  char
- s_ready  output  1  char accepted when s_valid && s_ready
- m_valid  output  1  message valid
- m_msg  output  MSG_WIDTH  packed message
- m_len  output  LEN_WIDTH  number of chars stored, 0..MAX_STR_LEN
- m_full  output  1  message was flushed because it filled, not because of a terminator
- m_ready  input  1  message consumed when m_valid && m_ready

Behaviour:
- Reset: the interface is decided as clock clk, reset rst_n, synchronous, active-low.
  - State=COLLECT, m_valid=0, m_msg=0, m_len=0, m_full=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards any partial or pending message. Nothing is emitted.
- States: COLLECT and EMIT.
  - s_ready = (state==COLLECT). Combinational from state only, never from m_ready.
  - m_valid = (state==EMIT). Registered.
- COLLECT, on an accepted beat:
  - s_char==TERM_CHAR: go to EMIT with m_full=0. m_len is unchanged; 0 is legal, giving an empty message with m_msg=0.
  - s_char==8'h00: dropped. No state change, because zero is padding in the packed format.
  - Otherwise: m_msg <= {m_msg[MSG_WIDTH-9:0], s_char}, m_len <= m_len+1.
  - If the new m_len==MAX_STR_LEN, go to EMIT with m_full=1 in the same cycle. The next char starts a new message.
- Latency: m_valid rises on the cycle after the beat that ends the message.
- EMIT:
  - m_msg, m_len and m_full are held stable while m_valid && !m_ready.
  - On m_valid && m_ready: next cycle state=COLLECT, m_msg=0, m_len=0, m_full=0, s_ready=1.
  - There is no overlap. A char cannot be accepted in the same cycle as the message handshake.
- m_msg, m_len and m_full are only meaningful while m_valid=1. In COLLECT they show the partial accumulation.
- A TERM_CHAR arriving right after a full flush produces an empty message (m_len=0, m_full=0). This is the required behaviour; it is not filtered.
- Throughput: one char per cycle while collecting. Each message costs at least one extra EMIT cycle.

Optional Feature:
- Macro: SVC_STR_COLLECT_BACKSPACE_EN.
- Defined: in COLLECT, an accepted 8'h08 or 8'h7F deletes the last stored char.
  - m_msg <= m_msg >> 8, m_len <= m_len-1.
  - At m_len==0 the char is ignored; no underflow.
  - The backspace char itself is never stored.
- Undefined: 8'h08 and 8'h7F are ordinary chars and are stored.

Test Plan:
- Send "Hello" then 8'h0A with m_ready=1 -> one cycle after the 0A beat: m_valid=1, m_msg==MSG_WIDTH'("Hello"), m_len=5, m_full=0. The next cycle has s_ready=1 and m_valid=0.
- Send 0A alone -> m_valid=1, m_len=0, m_msg=0, m_full=0.
- MAX_STR_LEN=16: send "0123456789abcdefXY" then 0A ->
  - First message "0123456789abcdef", m_len=16, m_full=1.
  - Second message "XY", m_len=2, m_full=0.
- Hold m_ready=0 for 5 cycles after the "Hi"+0A message ->
  - m_valid, m_msg and m_len stay stable.
  - s_ready=0 throughout, so an offered char 'Z' is not accepted.
  - After m_ready=1, 'Z' is accepted and starts the next message.
- Chars "A",8'h00,"B",0A -> m_msg==MSG_WIDTH'("AB"), m_len=2.
- Reset mid-stream: assert rst_n=0 after "Abc" with no terminator, then send "Q"+0A -> message "Q", m_len=1.
- Macro defined: "abX",8'h08,"c",0A -> "abc", m_len=3. Macro defined: 8'h7F as the first char, then 0A -> m_len=0.

Source files
------------

// File: rtl/svc_str_collect.sv
// Character-stream collector: packs accepted chars right-justified into a message and
// emits it on a terminator or when full. Optional backspace editing: SVC_STR_COLLECT_BACKSPACE_EN.
module svc_str_collect #(
   parameter int unsigned MAX_STR_LEN = 16,
   parameter logic [7:0]  TERM_CHAR   = 8'h0A,
   localparam int unsigned MSG_WIDTH  = MAX_STR_LEN * 8,
   localparam int unsigned LEN_WIDTH  = $clog2(MAX_STR_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   input  logic [7:0]           s_char,
   output logic                 s_ready,
   output logic                 m_valid,
   output logic [MSG_WIDTH-1:0] m_msg,
   output logic [LEN_WIDTH-1:0] m_len,
   output logic                 m_full,
   input  logic                 m_ready
);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_EMIT    = 1'b1
   } state_t;

   // Handshakes: a beat transfers on a rising clk edge where valid && ready.
   // s_ready depends on state only; a char and a message never transfer in the same cycle.

   state_t               r_state;
   logic                 r_valid;
   logic [MSG_WIDTH-1:0] r_msg;
   logic [LEN_WIDTH-1:0] r_len;
   logic                 r_full;

   logic                 w_is_term;
   logic                 w_is_null;
   logic                 w_is_bs;
   logic [MSG_WIDTH-1:0] w_msg_push;
   logic [LEN_WIDTH-1:0] w_len_inc;

   assign w_is_term  = (s_char == TERM_CHAR);
   assign w_is_null  = (s_char == 8'h00);
`ifdef SVC_STR_COLLECT_BACKSPACE_EN
   assign w_is_bs    = (s_char == 8'h08) || (s_char == 8'h7F);
`else
   assign w_is_bs    = 1'b0;
`endif
   // Shift-and-insert keeps the first char in the most significant used byte.
   assign w_msg_push = (r_msg << 8) | MSG_WIDTH'(s_char);
   assign w_len_inc  = r_len + LEN_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_COLLECT;
         r_valid <= 1'b0;
         r_msg   <= '0;
         r_len   <= '0;
         r_full  <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (s_valid) begin
                  if (w_is_term) begin
                     r_state <= ST_EMIT;
                     r_valid <= 1'b1;
                     r_full  <= 1'b0;
                  end else if (w_is_bs) begin
                     if (r_len != '0) begin
                        r_msg <= r_msg >> 8;
                        r_len <= r_len - LEN_WIDTH'(1);
                     end
                  end else if (!w_is_null) begin
                     r_msg <= w_msg_push;
                     r_len <= w_len_inc;
                     if (w_len_inc == LEN_WIDTH'(MAX_STR_LEN)) begin
                        r_state <= ST_EMIT;
                        r_valid <= 1'b1;
                        r_full  <= 1'b1;
                     end
                  end
               end
            end
            ST_EMIT: begin
               if (m_ready) begin
                  r_state <= ST_COLLECT;
                  r_valid <= 1'b0;
                  r_msg   <= '0;
                  r_len   <= '0;
                  r_full  <= 1'b0;
               end
            end
            default: r_state <= ST_COLLECT;
         endcase
      end
   end

   assign s_ready = (r_state == ST_COLLECT);
   assign m_valid = r_valid;
   assign m_msg   = r_msg;
   assign m_len   = r_len;
   assign m_full  = r_full;

endmodule

// File: tb/tb_svc_str_collect.sv
// Bench for svc_str_collect: string-level reference model checked every cycle,
// plus literal expectations for each emitted message.
module tb_svc_str_collect;

   localparam int unsigned MAX   = 16;
   localparam int unsigned MSG_W = MAX * 8;
   localparam int unsigned LEN_W = $clog2(MAX + 1);
   localparam int unsigned EXP_W = 1 + LEN_W + MSG_W;
   localparam logic [7:0]  TERM  = 8'h0A;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_valid;
   logic [7:0]       s_char;
   logic             s_ready;
   logic             m_valid;
   logic [MSG_W-1:0] m_msg;
   logic [LEN_W-1:0] m_len;
   logic             m_full;
   logic             m_ready;

   int total = 0;
   int bad   = 0;

   // model state: chars of the message being built, and ended-but-unconsumed messages
   logic [7:0]       cur_q[$];
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] got_q[$];

   svc_str_collect #(.MAX_STR_LEN(MAX), .TERM_CHAR(TERM)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_char  (s_char),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_msg   (m_msg),
      .m_len   (m_len),
      .m_full  (m_full),
      .m_ready (m_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [MSG_W-1:0] pack_cur();
      logic [MSG_W-1:0] v;
      int n;
      v = '0;
      n = cur_q.size();
      for (int i = 0; i < n; i++) v[(n - 1 - i) * 8 +: 8] = cur_q[i];
      return v;
   endfunction

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      logic             pend;
      logic [MSG_W-1:0] e_msg;
      logic [LEN_W-1:0] e_len;
      logic             e_full;
      if (!rst_n) begin
         cur_q.delete();
         exp_q.delete();
      end else begin
         pend = (exp_q.size() != 0);
         if (pend) begin
            e_msg  = exp_q[0][MSG_W-1:0];
            e_len  = exp_q[0][MSG_W +: LEN_W];
            e_full = exp_q[0][EXP_W-1];
         end else begin
            e_msg  = pack_cur();
            e_len  = LEN_W'(cur_q.size());
            e_full = 1'b0;
         end
         chk("m_valid", MSG_W'(m_valid), MSG_W'(pend));
         chk("s_ready", MSG_W'(s_ready), MSG_W'(!pend));
         chk("m_msg",   m_msg, e_msg);
         chk("m_len",   MSG_W'(m_len), MSG_W'(e_len));
         chk("m_full",  MSG_W'(m_full), MSG_W'(e_full));

         if (pend && m_ready) begin
            got_q.push_back({m_full, m_len, m_msg});
            void'(exp_q.pop_front());
         end else if (!pend && s_valid) begin
            if (s_char == TERM) begin
               exp_q.push_back({1'b0, LEN_W'(cur_q.size()), pack_cur()});
               cur_q.delete();
            end else if (s_char == 8'h00) begin
            end
`ifdef SVC_STR_COLLECT_BACKSPACE_EN
            else if (s_char == 8'h08 || s_char == 8'h7F) begin
               if (cur_q.size() > 0) void'(cur_q.pop_back());
            end
`endif
            else begin
               cur_q.push_back(s_char);
               if (cur_q.size() == MAX) begin
                  exp_q.push_back({1'b1, LEN_W'(MAX), pack_cur()});
                  cur_q.delete();
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_char(input logic [7:0] c);
      int  n;
      bit  done;
      n       = 0;
      done    = 0;
      s_valid = 1'b1;
      s_char  = c;
      while (!done) begin
         @(negedge clk);
         done = s_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: char %h not accepted after %0d cycles", c, n);
            done = 1;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input int idx, input logic [MSG_W-1:0] msg, input int len, input logic full);
      if (idx >= got_q.size()) begin
         total++;
         bad++;
         $display("FAIL lit%0d: message missing, got %0d messages", idx, got_q.size());
      end else begin
         chk($sformatf("lit%0d_msg", idx),  got_q[idx][MSG_W-1:0], msg);
         chk($sformatf("lit%0d_len", idx),  MSG_W'(got_q[idx][MSG_W +: LEN_W]), MSG_W'(len));
         chk($sformatf("lit%0d_full", idx), MSG_W'(got_q[idx][EXP_W-1]), MSG_W'(full));
      end
   endtask

   // ---------------- stimulus + final report ----------------
   initial begin
      int k;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_char  = 8'h00;
      m_ready = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(1);

      send_str("Hello"); send_char(TERM); idle(2);
      send_char(TERM); idle(2);
      send_str("0123456789abcdefXY"); send_char(TERM); idle(2);

      // message held back by m_ready=0 while 'Z' is offered
      m_ready = 1'b0;
      send_str("Hi"); send_char(TERM);
      s_valid = 1'b1;
      s_char  = "Z";
      idle(5);
      m_ready = 1'b1;
      send_char("Z"); send_char(TERM); idle(2);

      send_char("A"); send_char(8'h00); send_char("B"); send_char(TERM); idle(2);

`ifdef SVC_STR_COLLECT_BACKSPACE_EN
      send_str("abX"); send_char(8'h08); send_char("c"); send_char(TERM); idle(2);
      send_char(8'h7F); send_char(TERM); idle(2);
`else
      send_str("ab"); send_char(8'h08); send_char(TERM); idle(2);
`endif

      // reset mid-stream discards "Abc"
      send_str("Abc");
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_char("Q"); send_char(TERM); idle(3);

      k = 0;
      lit(k++, MSG_W'("Hello"), 5, 1'b0);
      lit(k++, '0, 0, 1'b0);
      lit(k++, MSG_W'("0123456789abcdef"), 16, 1'b1);
      lit(k++, MSG_W'("XY"), 2, 1'b0);
      lit(k++, MSG_W'("Hi"), 2, 1'b0);
      lit(k++, MSG_W'("Z"), 1, 1'b0);
      lit(k++, MSG_W'("AB"), 2, 1'b0);
`ifdef SVC_STR_COLLECT_BACKSPACE_EN
      lit(k++, MSG_W'("abc"), 3, 1'b0);
      lit(k++, '0, 0, 1'b0);
`else
      lit(k++, MSG_W'({"ab", 8'h08}), 3, 1'b0);
`endif
      lit(k++, MSG_W'("Q"), 1, 1'b0);
      chk("msg_count", MSG_W'(got_q.size()), MSG_W'(k));
      chk("model_drained", MSG_W'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
